// File: rtl/cordic_rotate_seq.sv
// -----------------------------------------------------------------------------
// cordic_rotate_seq
//
// Iterative circular-mode CORDIC rotation engine. Converts a polar pair
// (magnitude, angle) into rectangular form: x = m*cos(theta), y = m*sin(theta).
// One micro-rotation is performed per clock. It is the inverse companion of
// the pipelined vectoring unit and shares its angle encoding and arctangent
// constants (2^31 = 360 degrees, bit 31 of the angle is ignored).
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. The producer holds its data stable
// while valid is high and ready is low. in_ready is high only in IDLE;
// out_valid is high only in DONE, where x_out/y_out are held stable until the
// consumer raises out_ready. There is no overlap or queuing: one operation is
// in flight at a time.
//
// Sequence: IDLE -(accept)-> LOAD (gain pre-scale + quadrant fold)
//           -> ITER (ITERATIONS cycles) -> DONE -(out handshake)-> IDLE.
// With the accept edge at t, out_valid is high after edge t+ITERATIONS+1.
//
// Parameters:
//   ITERATIONS  number of micro-rotations, legal range 1..31
//   GAIN_INV    1/K in Q2.30 (CORDIC gain compensation), applied in LOAD
//
// Ports:
//   clock      in   system clock, all logic on the rising edge
//   reset_n    in   synchronous active-low reset (discards any operation)
//   in_valid   in   input request
//   in_ready   out  engine can accept (IDLE only)
//   magnitude  in   signed Q2.30, 1.0 = 32'h40000000, |m| < 2.0
//   angle      in   unsigned angle, 2^31 = 360 degrees, bit 31 ignored
//   out_valid  out  result available (DONE only)
//   out_ready  in   consumer accepts result
//   x_out      out  signed Q2.30, m*cos(theta)
//   y_out      out  signed Q2.30, m*sin(theta)
//   state_dbg  out  current FSM state (0 IDLE, 1 LOAD, 2 ITER, 3 DONE)
// -----------------------------------------------------------------------------
module cordic_rotate_seq #(
  parameter int          ITERATIONS = 17,
  parameter logic [31:0] GAIN_INV   = 32'h26DD3B6A
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] magnitude,
  input  logic [31:0] angle,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] x_out,
  output logic [31:0] y_out,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

  // ---------------------------------------------------------------------------
  // Arctangent table: round(atan(2^-i) * 2^31 / (2*pi)), same scaling as the
  // angle port. Entries 30 and 31 round to zero.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] atan_lut(input logic [4:0] idx);
    logic [31:0] v;
    case (idx)
      5'd0:    v = 32'h1000_0000;
      5'd1:    v = 32'h0972_0290;
      5'd2:    v = 32'h04FD_9C2E;
      5'd3:    v = 32'h0288_88EA;
      5'd4:    v = 32'h0145_8622;
      5'd5:    v = 32'h00A2_EBF1;
      5'd6:    v = 32'h0051_7B0F;
      5'd7:    v = 32'h0028_BE2B;
      5'd8:    v = 32'h0014_5F2A;
      5'd9:    v = 32'h000A_2F97;
      5'd10:   v = 32'h0005_17CC;
      5'd11:   v = 32'h0002_8BE6;
      5'd12:   v = 32'h0001_45F3;
      5'd13:   v = 32'h0000_A2FA;
      5'd14:   v = 32'h0000_517D;
      5'd15:   v = 32'h0000_28BE;
      5'd16:   v = 32'h0000_145F;
      5'd17:   v = 32'h0000_0A30;
      5'd18:   v = 32'h0000_0518;
      5'd19:   v = 32'h0000_028C;
      5'd20:   v = 32'h0000_0146;
      5'd21:   v = 32'h0000_00A3;
      5'd22:   v = 32'h0000_0051;
      5'd23:   v = 32'h0000_0029;
      5'd24:   v = 32'h0000_0014;
      5'd25:   v = 32'h0000_000A;
      5'd26:   v = 32'h0000_0005;
      5'd27:   v = 32'h0000_0003;
      5'd28:   v = 32'h0000_0001;
      5'd29:   v = 32'h0000_0001;
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t             state;
  state_t             state_next;

  logic signed [31:0] mag_r;      // magnitude captured on the accept edge
  logic        [30:0] ang_r;      // angle[30:0] captured on the accept edge
  logic signed [31:0] x_r;
  logic signed [31:0] y_r;
  logic signed [31:0] z_r;        // residual angle still to rotate
  logic        [4:0]  iter_cnt;

  // ---------------------------------------------------------------------------
  // LOAD: gain pre-scale and quadrant fold
  // ---------------------------------------------------------------------------
  logic signed [63:0] prod;
  logic signed [31:0] s;
  logic signed [31:0] x_load;
  logic signed [31:0] y_load;
  logic signed [31:0] z_load;

  assign prod = mag_r * $signed(GAIN_INV);
  // Q2.30 * Q2.30 = Q4.60; shifting right by 30 and keeping the low word
  // gives back Q2.30.
  assign s    = prod[61:30];

  always_comb begin
    x_load = s;
    y_load = '0;
    // Subtracting q*2^29 from a 31-bit angle whose top two bits are q simply
    // clears those bits, leaving a residual in [0, 90 degrees).
    z_load = {3'b000, ang_r[28:0]};
    case (ang_r[30:29])
      2'd0: begin
        x_load = s;
        y_load = '0;
      end
      2'd1: begin
        x_load = '0;
        y_load = s;
      end
      2'd2: begin
        x_load = -s;
        y_load = '0;
      end
      default: begin
        x_load = '0;
        y_load = -s;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // ITER: one micro-rotation, direction chosen by the sign of the residual
  // ---------------------------------------------------------------------------
  logic signed [31:0] x_shift;
  logic signed [31:0] y_shift;
  logic signed [31:0] atan_i;
  logic signed [31:0] x_next;
  logic signed [31:0] y_next;
  logic signed [31:0] z_next;

  assign x_shift = x_r >>> iter_cnt;
  assign y_shift = y_r >>> iter_cnt;
  assign atan_i  = atan_lut(iter_cnt);

  always_comb begin
    x_next = x_r;
    y_next = y_r;
    z_next = z_r;
    if (!z_r[31]) begin
      // z >= 0: rotate counter-clockwise (d = +1)
      x_next = x_r - y_shift;
      y_next = y_r + x_shift;
      z_next = z_r - atan_i;
    end else begin
      // z < 0: rotate clockwise (d = -1)
      x_next = x_r + y_shift;
      y_next = y_r - x_shift;
      z_next = z_r + atan_i;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid) state_next = S_LOAD;
      S_LOAD:  state_next = S_ITER;
      S_ITER:  if (iter_cnt == LAST_ITER) state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    state_dbg = state;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mag_r    <= '0;
      ang_r    <= '0;
      x_r      <= '0;
      y_r      <= '0;
      z_r      <= '0;
      iter_cnt <= '0;
      x_out    <= '0;
      y_out    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // in_ready is implied by being in IDLE
          if (in_valid) begin
            mag_r <= magnitude;
            ang_r <= angle[30:0];
          end
        end
        S_LOAD: begin
          x_r      <= x_load;
          y_r      <= y_load;
          z_r      <= z_load;
          iter_cnt <= '0;
        end
        S_ITER: begin
          x_r      <= x_next;
          y_r      <= y_next;
          z_r      <= z_next;
          iter_cnt <= iter_cnt + 5'd1;
          if (iter_cnt == LAST_ITER) begin
            x_out <= x_next;
            y_out <= y_next;
          end
        end
        default: begin
          // DONE: results held until the consumer takes them
        end
      endcase
    end
  end

  // Bits that are intentionally dropped: the angle wraps modulo 360 degrees
  // and the product keeps only its Q2.30 window.
  logic unused_bits;
  assign unused_bits = ^{angle[31], prod[63:62], prod[29:0]};

endmodule

// File: tb/tb_cordic_rotate_seq.sv
// -----------------------------------------------------------------------------
// tb_cordic_rotate_seq
//
// Self-checking bench for cordic_rotate_seq. Expected results come from an
// ideal floating-point polar-to-rectangular model (m*cos, m*sin) and are
// compared within the CORDIC accuracy bound; handshake timing is checked
// against the fixed ITERATIONS+1 latency.
// -----------------------------------------------------------------------------
module tb_cordic_rotate_seq;

  localparam int  ITERS = 17;
  localparam int  LAT   = ITERS + 1;
  localparam real TOL   = 131072.0;               // 32'h00020000 LSB
  localparam real PI    = 3.14159265358979323846;

  localparam logic [31:0] DIR_M [10] = '{
    32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h2000_0000,
    32'hC000_0000, 32'h4000_0000, 32'h4000_0000, 32'h3000_0000, 32'hE000_0000
  };
  localparam logic [31:0] DIR_A [10] = '{
    32'h0000_0000, 32'h0AAA_AAAB, 32'h3000_0000, 32'hB000_0000, 32'h6000_0000,
    32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h7FFF_FFFF, 32'h1C71_C71C
  };

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clock     = 1'b0;
  logic        reset_n   = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] magnitude = '0;
  logic [31:0] angle     = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] x_out;
  logic [31:0] y_out;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  cordic_rotate_seq #(
    .ITERATIONS (ITERS),
    .GAIN_INV   (32'h26DD3B6A)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .magnitude (magnitude),
    .angle     (angle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .state_dbg (state_dbg)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: ideal polar to rectangular, results in Q2.30 LSB units
  // ---------------------------------------------------------------------------
  function automatic void model(input logic [31:0] m, input logic [31:0] a,
                                output real ex, output real ey);
    real mr;
    real th;
    logic [30:0] a31;
    a31 = a[30:0];
    mr  = real'($signed(m));
    th  = real'(a31) * 2.0 * PI / 2147483648.0;
    ex  = mr * $cos(th);
    ey  = mr * $sin(th);
  endfunction

  function automatic real lsb_err(input logic [31:0] got, input real want);
    real d;
    d = real'($signed(got)) - want;
    return (d < 0.0) ? -d : d;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left just after a falling edge)
  // ---------------------------------------------------------------------------
  // Issue one request, scramble the inputs after the accept edge, and wait
  // (bounded) for out_valid. lat = edges from accept to out_valid, -1 on
  // timeout.
  task automatic run_op(input logic [31:0] m, input logic [31:0] a,
                        output logic [31:0] xo, output logic [31:0] yo,
                        output int lat);
    out_ready = 1'b0;
    magnitude = m;
    angle     = a;
    in_valid  = 1'b1;
    @(posedge clock);
    lat = 0;
    @(negedge clock);
    in_valid  = 1'b0;
    magnitude = $urandom;
    angle     = $urandom;
    while (!out_valid && lat < 100) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    if (!out_valid) lat = -1;
    xo = x_out;
    yo = y_out;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_tests++;
    if (x_out !== 32'h0 || y_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs got x=%h y=%h want 0 0", x_out, y_out);
    end
    n_tests++;
    if (state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL reset_state got %0d want 0", state_dbg);
    end
  endtask

  task automatic test_directed();
    logic [31:0] x, y;
    logic [31:0] rx [10];
    logic [31:0] ry [10];
    int lat;
    real ex, ey;
    for (int i = 0; i < 10; i++) begin
      run_op(DIR_M[i], DIR_A[i], x, y, lat);
      rx[i] = x;
      ry[i] = y;
      model(DIR_M[i], DIR_A[i], ex, ey);
      n_tests++;
      if (lat !== LAT) begin
        n_fail++; $display("FAIL dir_latency[%0d] got %0d want %0d", i, lat, LAT);
      end
      n_tests++;
      if (lsb_err(x, ex) > TOL) begin
        n_fail++; $display("FAIL dir_x[%0d] got %h want %.1f", i, x, ex);
      end
      n_tests++;
      if (lsb_err(y, ey) > TOL) begin
        n_fail++; $display("FAIL dir_y[%0d] got %h want %.1f", i, y, ey);
      end
      finish_op();
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL dir_handshake[%0d] got in_ready=%b out_valid=%b want 1 0",
                 i, in_ready, out_valid);
      end
    end
    // Angle bit 31 must not change the result.
    n_tests++;
    if (rx[3] !== rx[2] || ry[3] !== ry[2]) begin
      n_fail++;
      $display("FAIL dir_bit31 got x=%h y=%h want x=%h y=%h", rx[3], ry[3], rx[2], ry[2]);
    end
  endtask

  task automatic test_random();
    logic [31:0] m, a, x, y;
    int lat;
    real ex, ey;
    for (int i = 0; i < 24; i++) begin
      m = $urandom_range(32'h7999_9999, 32'h0);
      if ($urandom_range(1, 0) == 1) m = -m;
      a = $urandom;
      run_op(m, a, x, y, lat);
      model(m, a, ex, ey);
      n_tests++;
      if (lat !== LAT) begin
        n_fail++; $display("FAIL rnd_latency[%0d] got %0d want %0d", i, lat, LAT);
      end
      n_tests++;
      if (lsb_err(x, ex) > TOL) begin
        n_fail++; $display("FAIL rnd_x[%0d] m=%h a=%h got %h want %.1f", i, m, a, x, ex);
      end
      n_tests++;
      if (lsb_err(y, ey) > TOL) begin
        n_fail++; $display("FAIL rnd_y[%0d] m=%h a=%h got %h want %.1f", i, m, a, y, ey);
      end
      finish_op();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] m, a, hx, hy, x, y;
    int lat;
    real ex, ey;
    m = 32'h3000_0000;
    a = $urandom;
    run_op(m, a, hx, hy, lat);
    model(m, a, ex, ey);
    n_tests++;
    if (lat !== LAT || lsb_err(hx, ex) > TOL || lsb_err(hy, ey) > TOL) begin
      n_fail++;
      $display("FAIL bp_first got lat=%0d x=%h y=%h want lat=%0d x=%.1f y=%.1f",
               lat, hx, hy, LAT, ex, ey);
    end
    // Stall the consumer; in_valid pulses must be ignored.
    for (int k = 0; k < 10; k++) begin
      in_valid  = ($urandom_range(1, 0) == 1);
      magnitude = $urandom;
      angle     = $urandom;
      @(posedge clock);
      @(negedge clock);
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || state_dbg !== 2'd3 ||
          x_out !== hx || y_out !== hy) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got ov=%b ir=%b st=%0d x=%h y=%h want 1 0 3 %h %h",
                 k, out_valid, in_ready, state_dbg, x_out, y_out, hx, hy);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || x_out !== hx || y_out !== hy) begin
      n_fail++;
      $display("FAIL bp_release got ir=%b ov=%b x=%h y=%h want 1 0 %h %h",
               in_ready, out_valid, x_out, y_out, hx, hy);
    end
    // Next request offered right away, accepted on the following edge.
    m = 32'hD000_0000;
    a = $urandom;
    run_op(m, a, x, y, lat);
    model(m, a, ex, ey);
    n_tests++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT);
    end
    n_tests++;
    if (lsb_err(x, ex) > TOL || lsb_err(y, ey) > TOL) begin
      n_fail++; $display("FAIL b2b_data got x=%h y=%h want %.1f %.1f", x, y, ex, ey);
    end
    finish_op();
  endtask

  task automatic test_reset_mid();
    logic [31:0] m, a, x, y;
    int lat;
    int seen;
    real ex, ey;
    magnitude = 32'h4000_0000;
    angle     = 32'h1555_5555;
    in_valid  = 1'b1;
    @(posedge clock);                  // accept edge t
    @(negedge clock);
    in_valid  = 1'b0;
    repeat (5) @(negedge clock);       // now between edges t+5 and t+6
    n_tests++;
    if (state_dbg !== 2'd2 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_busy got st=%0d ir=%b want 2 0", state_dbg, in_ready);
    end
    @(negedge clock);
    reset_n = 1'b0;                    // sampled at edge t+7 (iteration i=5)
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || state_dbg !== 2'd0 ||
        x_out !== 32'h0 || y_out !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset got ir=%b ov=%b st=%0d x=%h y=%h want 1 0 0 0 0",
               in_ready, out_valid, state_dbg, x_out, y_out);
    end
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL mid_discard got %0d valid cycles want 0", seen);
    end
    m = 32'h4000_0000;
    a = 32'h0AAA_AAAB;
    run_op(m, a, x, y, lat);
    model(m, a, ex, ey);
    n_tests++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL mid_latency got %0d want %0d", lat, LAT);
    end
    n_tests++;
    if (lsb_err(x, ex) > TOL || lsb_err(y, ey) > TOL) begin
      n_fail++; $display("FAIL mid_data got x=%h y=%h want %.1f %.1f", x, y, ex, ey);
    end
    finish_op();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
